// File: rtl/sprite_scan_sched_if.sv
//------------------------------------------------------------------------------
// Module   : sprite_scan_sched_if
// Purpose  : Scan-side inputs and ROM-side outputs of the sprite scheduler.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sprite_scan_sched_if #(
    parameter int ADDR_W = 14
) ();
    logic              run;
    logic              frame_start;
    logic              de;
    logic [10:0]       h_pos;
    logic [10:0]       v_pos;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd_en;
    logic              spr_valid;
    logic              de_out;
    logic [10:0]       pos_x;
    logic [10:0]       pos_y;

    modport slave (
        input  run, frame_start, de, h_pos, v_pos,
        output rom_addr, rom_rd_en, spr_valid, de_out, pos_x, pos_y
    );

    modport master (
        output run, frame_start, de, h_pos, v_pos,
        input  rom_addr, rom_rd_en, spr_valid, de_out, pos_x, pos_y
    );
endinterface

`default_nettype wire

// File: rtl/sprite_scan_sched.sv
//------------------------------------------------------------------------------
// Module   : sprite_scan_sched
// Purpose  : Bouncing-sprite ROM read scheduler aligned to VGA scan-out.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sprite_scan_sched #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int SPR_W    = 48,
    parameter int SPR_H    = 48,
    parameter int STEP     = 1,
    parameter int ROM_LAT  = 1,
    parameter int ADDR_W   = 14
) (
    input  wire logic          clk,
    input  wire logic          rst,
    sprite_scan_sched_if.slave bus_if
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    localparam logic [11:0] MAX_X   = 12'(H_ACTIVE - SPR_W);
    localparam logic [11:0] MAX_Y   = 12'(V_ACTIVE - SPR_H);
    localparam logic [11:0] STEP12  = 12'(STEP);
    localparam logic [11:0] SPR_W12 = 12'(SPR_W);
    localparam logic [11:0] SPR_H12 = 12'(SPR_H);
    localparam logic [10:0] INIT_X  = 11'((H_ACTIVE - SPR_W) / 2);
    localparam logic [10:0] INIT_Y  = 11'((V_ACTIVE - SPR_H) / 2);

    state_t              state_q, state_d;
    logic [10:0]         pos_x_q, pos_x_d;
    logic [10:0]         pos_y_q, pos_y_d;
    logic                dir_neg_x_q, dir_neg_x_d;
    logic                dir_neg_y_q, dir_neg_y_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [ROM_LAT:0]    hit_pipe_q;
    logic [ROM_LAT:0]    de_pipe_q;
    logic                hit;
    logic                upd;
    logic [11:0]         h_ext, v_ext, px_ext, py_ext;

    assign h_ext  = {1'b0, bus_if.h_pos};
    assign v_ext  = {1'b0, bus_if.v_pos};
    assign px_ext = {1'b0, pos_x_q};
    assign py_ext = {1'b0, pos_y_q};

    // Any frame_start with run moves the sprite, including the one that leaves IDLE.
    assign upd = bus_if.frame_start & bus_if.run;

    assign hit = (state_q == S_ACTIVE) & bus_if.de
               & (h_ext >= px_ext) & (h_ext < px_ext + SPR_W12)
               & (v_ext >= py_ext) & (v_ext < py_ext + SPR_H12);

    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        dir_neg_x_d = dir_neg_x_q;
        dir_neg_y_d = dir_neg_y_q;
        rom_addr_d  = rom_addr_q;

        if (state_q == S_IDLE && bus_if.frame_start) begin
            state_d = S_ACTIVE;
        end

        if (upd) begin
            if (!dir_neg_x_q) begin
                if (px_ext + STEP12 >= MAX_X) begin
                    pos_x_d     = MAX_X[10:0];
                    dir_neg_x_d = 1'b1;
                end else begin
                    pos_x_d = pos_x_q + STEP12[10:0];
                end
            end else if (px_ext <= STEP12) begin
                pos_x_d     = '0;
                dir_neg_x_d = 1'b0;
            end else begin
                pos_x_d = pos_x_q - STEP12[10:0];
            end

            if (!dir_neg_y_q) begin
                if (py_ext + STEP12 >= MAX_Y) begin
                    pos_y_d     = MAX_Y[10:0];
                    dir_neg_y_d = 1'b1;
                end else begin
                    pos_y_d = pos_y_q + STEP12[10:0];
                end
            end else if (py_ext <= STEP12) begin
                pos_y_d     = '0;
                dir_neg_y_d = 1'b0;
            end else begin
                pos_y_d = pos_y_q - STEP12[10:0];
            end
        end

        // Offsets are non-negative whenever hit is set, so modular math is exact.
        if (hit) begin
            rom_addr_d = ADDR_W'(bus_if.v_pos - pos_y_q) * ADDR_W'(SPR_W)
                       + ADDR_W'(bus_if.h_pos - pos_x_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pos_x_q     <= INIT_X;
            pos_y_q     <= INIT_Y;
            dir_neg_x_q <= 1'b0;
            dir_neg_y_q <= 1'b0;
            rom_addr_q  <= '0;
            hit_pipe_q  <= '0;
            de_pipe_q   <= '0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_neg_x_q <= dir_neg_x_d;
            dir_neg_y_q <= dir_neg_y_d;
            rom_addr_q  <= rom_addr_d;
            hit_pipe_q  <= {hit_pipe_q[ROM_LAT-1:0], hit};
            de_pipe_q   <= {de_pipe_q[ROM_LAT-1:0], bus_if.de};
        end
    end

    assign bus_if.rom_addr  = rom_addr_q;
    assign bus_if.rom_rd_en = hit_pipe_q[0];
    assign bus_if.spr_valid = hit_pipe_q[ROM_LAT];
    assign bus_if.de_out    = de_pipe_q[ROM_LAT];
    assign bus_if.pos_x     = pos_x_q;
    assign bus_if.pos_y     = pos_y_q;

endmodule

`default_nettype wire
